// File: rtl/display_prefetch_if.sv
// display_prefetch_if: port-0 burst read channel between prefetcher and SRAM arbiter.
interface display_prefetch_if;
  logic        req;
  logic        we;
  logic [23:0] addr;
  logic [7:0]  burst_len;
  logic [15:0] burst_rdata;
  logic        burst_data_valid;
  logic        ack;

  modport master (
    output req, we, addr, burst_len,
    input  burst_rdata, burst_data_valid, ack
  );

  modport slave (
    input  req, we, addr, burst_len,
    output burst_rdata, burst_data_valid, ack
  );
endinterface

// File: rtl/display_prefetch.sv
// display_prefetch: scan-out prefetcher streaming framebuffer bursts into a FWFT FIFO.
// DISPLAY_PREFETCH_STATS_EN adds underrun_count and fifo_min_level outputs.
module display_prefetch #(
  parameter int FIFO_DEPTH  = 64,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_WORDS = 307200
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_start,
  input  logic [23:0]                fb_base,
  display_prefetch_if.master         mem,
  input  logic                       pix_rd,
  output logic [15:0]                pix_data,
  output logic                       pix_valid,
  output logic                       underrun,
  output logic                       frame_done
`ifdef DISPLAY_PREFETCH_STATS_EN
  ,
  output logic [15:0]                underrun_count,
  output logic [$clog2(FIFO_DEPTH):0] fifo_min_level
`endif
);

  localparam int          AW     = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] BLEN   = (AW+1)'(BURST_LEN);
  localparam logic [AW:0] ONE    = (AW+1)'(1);
  localparam logic [23:0] FRAME  = 24'(FRAME_WORDS);
  localparam logic [23:0] BLEN24 = 24'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DRAIN} state_t;

  state_t      state;
  logic [23:0] fetch_addr;
  logic [23:0] remaining;
  logic [23:0] pend_base;
  logic [7:0]  beat_cnt;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] level;
  logic [AW:0] space;
  logic [15:0] fifo [FIFO_DEPTH];
  logic [15:0] last_data;
  logic        busy;
  logic        push;
  logic        pop;
  logic        flush;
  logic        start_ok;
  logic [23:0] new_base;

  assign level     = wr_ptr - rd_ptr;
  assign space     = DEPTH - level;
  assign pix_valid = (level != '0);
  assign pix_data  = pix_valid ? fifo[rd_ptr[AW-1:0]] : last_data;
  assign busy      = (state == REQ) || (state == XFER);
  // Beats past the granted length are ignored so the FIFO can never overflow.
  assign push      = busy && !frame_start && mem.burst_data_valid
                     && (beat_cnt < mem.burst_len);
  assign pop       = pix_rd && pix_valid;
  assign flush     = ((state == IDLE) && frame_start)
                     || (busy && frame_start && mem.ack)
                     || ((state == DRAIN) && mem.ack);
  assign start_ok  = (state == IDLE) && !frame_start
                     && (remaining != '0) && (space >= BLEN);
  assign new_base  = frame_start ? fb_base : pend_base;
  assign mem.we    = 1'b0;

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr[AW-1:0]] <= mem.burst_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      fetch_addr    <= '0;
      remaining     <= '0;
      pend_base     <= '0;
      beat_cnt      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      last_data     <= '0;
      mem.req       <= 1'b0;
      mem.addr      <= '0;
      mem.burst_len <= '0;
      underrun      <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      underrun   <= pix_rd && !pix_valid;
      frame_done <= 1'b0;
      if (pix_valid) last_data <= fifo[rd_ptr[AW-1:0]];

      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fetch_addr <= new_base;
        remaining  <= FRAME;
      end else begin
        if (push) wr_ptr <= wr_ptr + ONE;
        if (pop)  rd_ptr <= rd_ptr + ONE;
      end

      if (push) begin
        fetch_addr <= fetch_addr + 24'd1;
        remaining  <= remaining - 24'd1;
        beat_cnt   <= beat_cnt + 8'd1;
        if (remaining == 24'd1) frame_done <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (start_ok) begin
            state         <= REQ;
            mem.req       <= 1'b1;
            mem.addr      <= fetch_addr;
            mem.burst_len <= (remaining < BLEN24) ? remaining[7:0]
                                                  : BLEN24[7:0];
            beat_cnt      <= '0;
          end
        end
        REQ, XFER: begin
          if (frame_start) begin
            pend_base <= fb_base;
            // A granted burst cannot be cancelled; drain it unless it ends now.
            if (mem.ack) begin
              state   <= IDLE;
              mem.req <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end else if (mem.ack) begin
            state   <= IDLE;
            mem.req <= 1'b0;
          end else if (mem.burst_data_valid) begin
            state <= XFER;
          end
        end
        DRAIN: begin
          if (frame_start) pend_base <= fb_base;
          if (mem.ack) begin
            state   <= IDLE;
            mem.req <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISPLAY_PREFETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_count <= '0;
      fifo_min_level <= DEPTH;
    end else if (frame_start) begin
      underrun_count <= '0;
      fifo_min_level <= DEPTH;
    end else begin
      if (pix_rd && !pix_valid && (underrun_count != 16'hFFFF))
        underrun_count <= underrun_count + 16'd1;
      if (level < fifo_min_level) fifo_min_level <= level;
    end
  end
`endif

endmodule

// File: tb/tb_display_prefetch.sv
// tb_display_prefetch: directed checks of display_prefetch against arbiter models.
module tb_display_prefetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        fs0 = 1'b0, fs1 = 1'b0;
  logic [23:0] base0 = '0, base1 = '0;
  logic        rd0 = 1'b0, rd1 = 1'b0;
  logic [15:0] pd0, pd1;
  logic        pv0, pv1, ur0, ur1, fd0, fd1;
`ifdef DISPLAY_PREFETCH_STATS_EN
  logic [15:0] uc0, uc1;
  logic [6:0]  ml0, ml1;
`endif

  display_prefetch_if b0 ();
  display_prefetch_if b1 ();

  display_prefetch u0 (
    .clk(clk), .rst_n(rst_n), .frame_start(fs0), .fb_base(base0),
    .mem(b0), .pix_rd(rd0), .pix_data(pd0), .pix_valid(pv0),
    .underrun(ur0), .frame_done(fd0)
`ifdef DISPLAY_PREFETCH_STATS_EN
    , .underrun_count(uc0), .fifo_min_level(ml0)
`endif
  );

  display_prefetch #(.FRAME_WORDS(40)) u1 (
    .clk(clk), .rst_n(rst_n), .frame_start(fs1), .fb_base(base1),
    .mem(b1), .pix_rd(rd1), .pix_data(pd1), .pix_valid(pv1),
    .underrun(ur1), .frame_done(fd1)
`ifdef DISPLAY_PREFETCH_STATS_EN
    , .underrun_count(uc1), .fifo_min_level(ml1)
`endif
  );

  // Arbiter models: one idle cycle after req, then beats carrying addr[15:0].
  int          ack_after0 = 0;
  logic        m0_busy, m1_busy;
  int          m0_cnt, m0_len, m1_cnt, m1_len;
  logic [23:0] m0_a, m1_a;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_busy <= 1'b0; m0_cnt <= 0; m0_len <= 0; m0_a <= '0;
      b0.burst_data_valid <= 1'b0; b0.ack <= 1'b0; b0.burst_rdata <= '0;
    end else begin
      b0.burst_data_valid <= 1'b0;
      b0.ack <= 1'b0;
      if (!m0_busy) begin
        if (b0.req && !b0.ack) begin
          m0_busy <= 1'b1;
          m0_cnt  <= 0;
          m0_a    <= b0.addr;
          m0_len  <= (ack_after0 != 0) ? ack_after0 : int'(b0.burst_len);
        end
      end else begin
        b0.burst_data_valid <= 1'b1;
        b0.burst_rdata <= m0_a[15:0] + 16'(m0_cnt);
        m0_cnt <= m0_cnt + 1;
        if (m0_cnt == m0_len - 1) begin
          b0.ack  <= 1'b1;
          m0_busy <= 1'b0;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_busy <= 1'b0; m1_cnt <= 0; m1_len <= 0; m1_a <= '0;
      b1.burst_data_valid <= 1'b0; b1.ack <= 1'b0; b1.burst_rdata <= '0;
    end else begin
      b1.burst_data_valid <= 1'b0;
      b1.ack <= 1'b0;
      if (!m1_busy) begin
        if (b1.req && !b1.ack) begin
          m1_busy <= 1'b1;
          m1_cnt  <= 0;
          m1_a    <= b1.addr;
          m1_len  <= int'(b1.burst_len);
        end
      end else begin
        b1.burst_data_valid <= 1'b1;
        b1.burst_rdata <= m1_a[15:0] + 16'(m1_cnt);
        m1_cnt <= m1_cnt + 1;
        if (m1_cnt == m1_len - 1) begin
          b1.ack  <= 1'b1;
          m1_busy <= 1'b0;
        end
      end
    end
  end

  logic [23:0] rq0_a[$], rq1_a[$];
  logic [7:0]  rq0_l[$], rq1_l[$];
  logic        p0 = 1'b0, p1 = 1'b0;
  int          beats1 = 0, fdn1 = 0;

  always @(posedge clk) begin
    if (b0.req && !p0) begin
      rq0_a.push_back(b0.addr);
      rq0_l.push_back(b0.burst_len);
    end
    if (b1.req && !p1) begin
      rq1_a.push_back(b1.addr);
      rq1_l.push_back(b1.burst_len);
    end
    if (b1.req && b1.burst_data_valid) beats1++;
    if (fd1) fdn1++;
    p0 = b0.req;
    p1 = b1.req;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse0(logic [23:0] b);
    base0 = b;
    fs0 = 1'b1;
    @(negedge clk);
    fs0 = 1'b0;
  endtask

  task automatic pop0(int n, logic [15:0] start, string tag);
    for (int i = 0; i < n; i++) begin
      check(tag, {15'd0, pv0, pd0}, {15'd0, 1'b1, 16'(start + 16'(i))});
      rd0 = 1'b1;
      @(negedge clk);
    end
    rd0 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_req", b0.req, 0);
    check("rst_we", b0.we, 0);
    check("rst_addr", b0.addr, 0);
    check("rst_len", b0.burst_len, 0);
    check("rst_valid", pv0, 0);
    check("rst_data", pd0, 0);
    check("rst_underrun", ur0, 0);
    check("rst_done", fd0, 0);
    tick(10);
    check("no_fetch_before_start", b0.req, 0);
    check("no_fetch_before_start1", b1.req, 0);

    n = 0;
    rd0 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ur0) n++;
    end
    rd0 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ur0) n++;
    end
    check("underrun_pulses", n, 3);
    check("underrun_still_empty", pv0, 0);
`ifdef DISPLAY_PREFETCH_STATS_EN
    check("underrun_count", uc0, 3);
`endif

    pulse0(24'h001000);
`ifdef DISPLAY_PREFETCH_STATS_EN
    check("underrun_count_clear", uc0, 0);
`endif
    for (int t = 0; t < 50 && rq0_a.size() < 1; t++) @(negedge clk);
    check("first_req_seen", rq0_a.size() >= 1, 1);
    if (rq0_a.size() >= 1) begin
      check("first_req_addr", rq0_a[0], 24'h001000);
      check("first_req_len", rq0_l[0], 16);
    end
    tick(300);
    check("hold_four_bursts", rq0_a.size(), 4);
    if (rq0_a.size() >= 2) check("second_req_addr", rq0_a[1], 24'h001010);
    check("hold_req_low", b0.req, 0);

    pop0(16, 16'h1000, "pop_order_a");
    tick(100);
    check("refill_burst", rq0_a.size(), 5);
    if (rq0_a.size() >= 5) check("refill_addr", rq0_a[4], 24'h001040);
    pop0(48, 16'h1010, "pop_order_b");
    tick(300);

    ack_after0 = 5;
    k = rq0_a.size();
    pulse0(24'h002000);
    tick(200);
    check("early_req_count", rq0_a.size() >= k + 2, 1);
    if (rq0_a.size() >= k + 2) begin
      check("early_first_addr", rq0_a[k], 24'h002000);
      check("early_first_len", rq0_l[k], 16);
      check("early_next_addr", rq0_a[k+1], 24'h002005);
      check("early_next_len", rq0_l[k+1], 16);
    end
    pop0(8, 16'h2000, "early_no_gap");

    ack_after0 = 0;
    tick(200);
    pulse0(24'h003000);
    for (int t = 0; t < 50 && !b0.burst_data_valid; t++) @(negedge clk);
    check("xfer_started", b0.burst_data_valid, 1);
    tick(3);
    k = rq0_a.size();
    pulse0(24'h200000);
    for (int t = 0; t < 40 && !b0.ack; t++) @(negedge clk);
    check("drain_ack_seen", b0.ack, 1);
    @(negedge clk);
    check("drain_fifo_empty", pv0, 0);
    check("drain_req_low", b0.req, 0);
    check("drain_no_extra_req", rq0_a.size(), k);
    for (int t = 0; t < 20 && rq0_a.size() <= k; t++) @(negedge clk);
    check("restart_req_seen", rq0_a.size() > k, 1);
    if (rq0_a.size() > k) begin
      check("restart_addr", rq0_a[k], 24'h200000);
      check("restart_len", rq0_l[k], 16);
    end
    tick(30);
    pop0(2, 16'h0000, "restart_data");

    base1 = 24'h000100;
    fs1 = 1'b1;
    @(negedge clk);
    fs1 = 1'b0;
    for (int t = 0; t < 200 && !fd1; t++) @(negedge clk);
    check("frame_done_seen", fd1, 1);
    check("frame_done_beat", beats1, 40);
    tick(100);
    check("frame_done_once", fdn1, 1);
    check("short_req_count", rq1_a.size(), 3);
    if (rq1_a.size() >= 3) begin
      check("short_len0", rq1_l[0], 16);
      check("short_len1", rq1_l[1], 16);
      check("short_len2", rq1_l[2], 8);
      check("short_addr2", rq1_a[2], 24'h000120);
    end
    check("short_req_low", b1.req, 0);
    check("short_head", {15'd0, pv1, pd1}, {15'd0, 1'b1, 16'h0100});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
